// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, FSM state type and partial-product shift helper for the sequential multiplier
package mult_pkg;
   localparam int NIB_W = 4;
   localparam int PP_W  = 8;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic logic [4:0] shift_amt(input logic [1:0] i, input logic [1:0] j);
      return {({1'b0, i} + {1'b0, j}), 2'b00};
   endfunction
endpackage

// File: rtl/mult_nib4x4.sv
// mult_nib4x4: combinational 4x4 unsigned array multiplier slice
module mult_nib4x4
   import mult_pkg::*;
(
   input  logic [NIB_W-1:0] x_i,
   input  logic [NIB_W-1:0] y_i,
   output logic [PP_W-1:0]  p_o
);
   // sum of the four AND-gated, shifted rows of the array
   always_comb begin
      p_o = '0;
      for (int k = 0; k < NIB_W; k++)
         p_o = p_o + ({{(PP_W-NIB_W){1'b0}}, x_i & {NIB_W{y_i[k]}}} << k);
   end
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: OP_W x OP_W multiply built from one shared 4x4 slice, one nibble pair per cycle
// Optional MULT_SEQ_ACC_EN adds an acc input that keeps the accumulator across operations.
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int OP_W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef MULT_SEQ_ACC_EN
   input  logic              acc,
`endif
   output logic [2*OP_W-1:0] result
);
   localparam int K = OP_W / NIB_W;
   localparam int ACC_W = 2 * OP_W;
   localparam logic [1:0] KM1 = 2'(K - 1);

   if (OP_W % NIB_W != 0 || K < 1 || K > 4) begin : g_bad_op_w
      $error("mult_seq_ctrl: OP_W must be 4, 8, 12 or 16");
   end

   state_t            state_q, state_d;
   logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [1:0]        i_q, i_d, j_q, j_d;
   logic [NIB_W-1:0]  a_nib, b_nib;
   logic [PP_W-1:0]   pp;
   logic              clr_acc;

`ifdef MULT_SEQ_ACC_EN
   assign clr_acc = ~acc;
`else
   assign clr_acc = 1'b1;
`endif

   assign a_nib  = NIB_W'(a_q >> {i_q, 2'b00});
   assign b_nib  = NIB_W'(b_q >> {j_q, 2'b00});
   assign result = acc_q;

   mult_nib4x4 u_nib (
      .x_i (a_nib),
      .y_i (b_nib),
      .p_o (pp)
   );

   // state, operand, counter and accumulator registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         i_q     <= i_d;
         j_q     <= j_d;
      end
   end

   // next state: accept operands, walk i fastest then j, hold result until taken
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      i_d       = i_q;
      j_d       = j_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               acc_d   = clr_acc ? '0 : acc_q;
               i_d     = '0;
               j_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d   = acc_q + (ACC_W'(pp) << shift_amt(i_q, j_q));
            i_d     = (i_q == KM1) ? 2'd0 : i_q + 2'd1;
            j_d     = (i_q == KM1) ? ((j_q == KM1) ? 2'd0 : j_q + 2'd1) : j_q;
            state_d = (i_q == KM1 && j_q == KM1) ? DONE : RUN;
         end
         DONE: begin
            out_valid = 1'b1;
            state_d   = out_ready ? IDLE : DONE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: randomized self-checking bench for mult_seq_ctrl against an arithmetic model
module tb_mult_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a, b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
`ifdef MULT_SEQ_ACC_EN
   logic        acc;
`endif
   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] model_acc = '0;

   mult_seq_ctrl #(.OP_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef MULT_SEQ_ACC_EN
      .acc       (acc),
`endif
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one full transaction: offer operands, measure latency, stall, then hand off
   task automatic op(input logic [7:0] x, input logic [7:0] y, input int stall, input logic accf);
      int n;
      logic [15:0] exp;
      exp = accf ? model_acc + 16'(x) * 16'(y) : 16'(x) * 16'(y);
      a = x;
      b = y;
      in_valid = 1'b1;
      out_ready = 1'b0;
`ifdef MULT_SEQ_ACC_EN
      acc = accf;
`endif
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      n = 0;
      while (!out_valid && n < 50) begin
         check("in_ready_busy", 32'(in_ready), 32'd0);
         tick();
         n++;
      end
      check("latency", 32'(n), 32'd4);
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b1;
         check("hold_result", 32'(result), 32'(exp));
         check("hold_valid", 32'(out_valid), 32'd1);
         check("ignore_in_valid", 32'(in_ready), 32'd0);
         tick();
      end
      in_valid = 1'b0;
      check("result", 32'(result), 32'(exp));
      check("out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid_drop", 32'(out_valid), 32'd0);
      check("in_ready_back", 32'(in_ready), 32'd1);
      model_acc = exp;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
`ifdef MULT_SEQ_ACC_EN
      acc = 1'b0;
`endif
      tick();
      tick();
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      rst_n = 1'b1;
      op(8'h0D, 8'h05, 0, 1'b0);
      op(8'hFF, 8'hFF, 1, 1'b0);
      op(8'h00, 8'hA7, 0, 1'b0);
      op(8'h12, 8'h34, 10, 1'b0);
      a = 8'h0F;
      b = 8'h0F;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      check("midrun_reset_in_ready", 32'(in_ready), 32'd1);
      check("midrun_reset_out_valid", 32'(out_valid), 32'd0);
      check("midrun_reset_result", 32'(result), 32'd0);
      rst_n = 1'b1;
      model_acc = '0;
      op(8'h03, 8'h04, 0, 1'b0);
      for (int t = 0; t < 1000; t++)
         op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
`ifdef MULT_SEQ_ACC_EN
      op(8'h0D, 8'h05, 0, 1'b0);
      check("acc_first", 32'(result), 32'h0041);
      op(8'h02, 8'h03, 0, 1'b1);
      check("acc_second", 32'(result), 32'h0047);
      op(8'hFF, 8'hFF, 0, 1'b1);
      check("acc_third", 32'(result), 32'hFE48);
      for (int t = 0; t < 200; t++)
         op(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
